imm_gen_pipe: RTL
=================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined RV32/RV64 core. It takes one fetched instruction word per handshake and classifies its format. It produces a fully sign-extended XLEN immediate and presents the result through 1 or 2 elastic register stages with valid/ready flow control. It sits between fetch and register read, replaces the combinational single-cycle decoder, and keeps an optional legacy sign/magnitude output for the existing ALU ADDI path.

## Interface
- XLEN, 32, datapath width; 32 or 64 only.
- STAGES, 1, number of register stages; 1 or 2 only.
- LEGACY_MAG, 0, 1 = OP-IMM non-shift immediates output as magnitude plus out_neg.
- TAG_W, 8, width of sideband tag carried alongside the instruction.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  in_instr/in_tag valid.
- in_ready  output  1  block accepts the input this cycle.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  opaque sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_neg  output  1  immediate negative (see Operation).
- out_illegal  output  1  opcode not in the decode table.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Opcode is in_instr[6:0]; decode is combinational in front of stage 1.
- Opcode-to-format mapping:
  - 0110011, 0001011: R; imm 0.
  - 0010011, 0000011, 1100111: I.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - Any other opcode: fmt 7, out_illegal=1, imm 0, out_neg 0.
- Immediate assembly; every format is sign-extended from in_instr[31] to XLEN unless stated otherwise:
  - I: in_instr[31:20].
  - S: {in_instr[31:25], in_instr[11:7]}.
  - B: {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}.
  - U: {in_instr[31:12], 12'b0}.
  - J: {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}.
- Shifts: opcode 0010011 with funct3 001/101 gives imm = shamt, zero-extended. shamt = in_instr[24:20] for XLEN=32 and in_instr[25:20] for XLEN=64; funct7 bits are not part of imm.
- out_neg when LEGACY_MAG=0: out_neg = out_imm[XLEN-1].
- out_neg when LEGACY_MAG=1:
  - Opcode 0010011 non-shift: out_imm = zero-extended 12-bit two's-complement magnitude of in_instr[31:20], and out_neg = in_instr[31]. For 0x800, magnitude = 0x800 (2048).
  - All other opcodes: decoded as in LEGACY_MAG=0, out_neg = 0.
- Pipeline:
  - Each stage holds valid and data; stage k loads when it is empty or stage k+1 (or the consumer) takes its data in the same cycle.
  - in_ready = !v[0] | ready_into_stage0_downstream; full throughput, one result per cycle, no bubbles.
  - Stage 2, when present, is a plain register copy of stage 1; no logic is added there.
- Stall: while out_valid && !out_ready, all out_* stay bit-stable and no input is lost.
- Flush: clears every stage valid at the edge. An input handshaking in the flush cycle is discarded. in_ready is unaffected by flush.
- Reset: all stage valids 0, out_imm 0, out_fmt 0, out_neg 0, out_illegal 0, out_tag 0. Reset has priority over flush and handshakes, including mid-stream.

## Timing
- Latency: STAGES cycles from input handshake to out_valid.
- out_* are driven directly from the last stage registers; there is no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- A full pipeline with out_ready=1 accepts and emits in the same cycle.
- First cycle after rst_n rises: in_ready=1, out_valid=0.

## Test plan
- ADDI x,x,5 (0x00550513), XLEN=32, STAGES=1 -> one cycle later: out_imm=0x00000005, fmt=1, neg=0.
- ADDI imm -7 (0xFF950513):
  - LEGACY_MAG=0 -> out_imm=0xFFFFFFF9, neg=1.
  - LEGACY_MAG=1 -> out_imm=0x00000007, neg=1.
  - imm 0x800 with LEGACY_MAG=1 -> out_imm=0x00000800.
- Format sweep, XLEN=64:
  - BEQ offset -4 (0xFE000EE3) -> 0xFFFFFFFFFFFFFFFC, fmt=3.
  - JAL +2048 (0x001000EF) -> 0x800, fmt=5.
  - LUI 0x80000 (0x800000B7) -> 0xFFFFFFFF80000000, fmt=4.
  - SLLI shamt 33 (0x02151513) -> 0x21.
- Backpressure, STAGES=2: stream 6 instructions with out_ready toggling 1,0,0,1,...
  - All 6 are received in order with matching tags; no drops or duplicates.
  - Outputs hold during stalls.
  - Throughput is 1/cycle when out_ready=1.
- Opcode 0x7F -> fmt=7, out_illegal=1, imm=0. Opcode 0110011 -> fmt=0, imm=0, illegal=0.
- Flush and reset:
  - Flush with both stages full plus an input handshake in the same cycle -> next cycle out_valid=0; the flushed inputs never appear.
  - rst_n=0 asserted mid-stream -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32/RV64 immediate generator with valid/ready elastic stages
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int STAGES     = 1,
    parameter bit LEGACY_MAG = 1'b0,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_neg,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             neg;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } pay_t;

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                           FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

    logic [6:0]  opcode;
    logic        is_opimm;
    logic        is_shift;
    logic [5:0]  shamt;
    logic [11:0] mag;
    logic [31:0] raw;
    pay_t        dec;

    assign opcode   = in_instr[6:0];
    assign is_opimm = (opcode == 7'b0010011);
    assign is_shift = is_opimm && (in_instr[13:12] == 2'b01);
    assign shamt    = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    assign mag      = in_instr[31] ? (~in_instr[31:20] + 12'd1) : in_instr[31:20];

    // Immediate is built as a sign-extended 32-bit value, then widened once to XLEN.
    always_comb begin
        raw     = '0;
        dec     = '0;
        dec.tag = in_tag;
        case (opcode)
            7'b0110011, 7'b0001011: dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                raw     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                raw     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                raw     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                raw     = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                raw     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                dec.fmt = FMT_X;
                dec.ill = 1'b1;
            end
        endcase
        if (is_shift) begin
            raw = {26'b0, shamt};
        end
        if (LEGACY_MAG) begin
            // Sign/magnitude form for the legacy ADDI path; sign travels in neg only.
            if (is_opimm && !is_shift) begin
                raw     = {20'b0, mag};
                dec.neg = in_instr[31];
            end
        end else begin
            dec.neg = raw[31];
        end
        dec.imm = XLEN'($signed(raw));
    end

    logic v0;
    pay_t d0;
    logic take0;

    assign in_ready = !v0 || take0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            d0 <= '0;
        end else begin
            if (flush) begin
                v0 <= 1'b0;
            end else if (in_ready) begin
                v0 <= in_valid;
            end
            if (in_valid && in_ready) begin
                d0 <= dec;
            end
        end
    end

    pay_t dl;
    logic vl;

    generate
        if (STAGES == 2) begin : g_two
            logic v1;
            pay_t d1;

            assign take0 = !v1 || out_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v1 <= 1'b0;
                    d1 <= '0;
                end else begin
                    if (flush) begin
                        v1 <= 1'b0;
                    end else if (take0) begin
                        v1 <= v0;
                    end
                    if (take0 && v0) begin
                        d1 <= d0;
                    end
                end
            end

            assign vl = v1;
            assign dl = d1;
        end else begin : g_one
            assign take0 = out_ready;
            assign vl    = v0;
            assign dl    = d0;
        end
    endgenerate

    assign out_valid   = vl;
    assign out_imm     = dl.imm;
    assign out_fmt     = dl.fmt;
    assign out_neg     = dl.neg;
    assign out_illegal = dl.ill;
    assign out_tag     = dl.tag;

endmodule
